// File: rtl/vx_stream_packer.sv
// Packs RATIO narrow valid/ready beats into one lane-masked word and pushes it
// into a downstream FIFO, with a one-word holding register decoupling ingest from drain.
module vx_stream_packer #(
  parameter  int DATAW = 4,
  parameter  int RATIO = 4,
  localparam int OUTW  = DATAW * RATIO
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [DATAW-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             full,
  output logic             push,
  output logic [OUTW-1:0]  data_out,
  output logic [RATIO-1:0] mask_out,
  output logic             idle
);

  localparam int CNTW = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [CNTW-1:0]  cnt_q,     cnt_d;
  logic [OUTW-1:0]  staging_q, staging_d;
  logic [RATIO-1:0] fill_q,    fill_d;
  logic [OUTW-1:0]  hold_q,    hold_d;
  logic [RATIO-1:0] hmask_q,   hmask_d;
  logic             pending_q, pending_d;

  logic             accept;
  logic             complete;
  logic [RATIO-1:0] mask_new;
  logic [OUTW-1:0]  merged;
  logic [OUTW-1:0]  lane_keep;

  assign in_ready = !pending_q || !full;
  assign push     = pending_q && !full;
  assign accept   = in_valid && in_ready;
  assign complete = accept && ((cnt_q == CNTW'(RATIO - 1)) || in_last);
  assign mask_new = fill_q | (RATIO'(1) << cnt_q);
  assign data_out = hold_q;
  assign mask_out = hmask_q;
  assign idle     = (cnt_q == '0) && !pending_q;

  // Insert the incoming beat into its lane and build a bit mask of filled lanes.
  always_comb begin
    merged    = staging_q;
    lane_keep = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (CNTW'(k) == cnt_q) merged[k*DATAW +: DATAW] = in_data;
      if (mask_new[k])       lane_keep[k*DATAW +: DATAW] = {DATAW{1'b1}};
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    staging_d = staging_q;
    fill_d    = fill_q;
    hold_d    = hold_q;
    hmask_d   = hmask_q;
    pending_d = pending_q;
    if (push) pending_d = 1'b0;
    if (complete) begin
      // A completing beat overrides a same-edge push: the drained word leaves
      // while the new one lands in the holding register.
      hold_d    = merged & lane_keep;
      hmask_d   = mask_new;
      pending_d = 1'b1;
      cnt_d     = '0;
      staging_d = '0;
      fill_d    = '0;
    end else if (accept) begin
      cnt_d     = cnt_q + CNTW'(1);
      staging_d = merged;
      fill_d    = mask_new;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      staging_q <= '0;
      fill_q    <= '0;
      hold_q    <= '0;
      hmask_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      staging_q <= staging_d;
      fill_q    <= fill_d;
      hold_q    <= hold_d;
      hmask_q   <= hmask_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_vx_stream_packer.sv
// Bench for vx_stream_packer: directed scenarios plus randomized traffic checked
// against a beat-queue reference model and a small downstream FIFO.
module tb_vx_stream_packer;

  localparam int DATAW = 4;
  localparam int RATIO = 4;
  localparam int OUTW  = DATAW * RATIO;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic [DATAW-1:0] in_data;
  logic             in_last;
  logic             in_ready;
  logic             full;
  logic             push;
  logic [OUTW-1:0]  data_out;
  logic [RATIO-1:0] mask_out;
  logic             idle;

  vx_stream_packer #(.DATAW(DATAW), .RATIO(RATIO)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .full     (full),
    .push     (push),
    .data_out (data_out),
    .mask_out (mask_out),
    .idle     (idle)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: beats of the open word, plus the word waiting for the FIFO.
  int              m_beats[$];
  bit              m_pend;
  logic [OUTW-1:0] m_data;
  logic [RATIO-1:0] m_mask;

  logic [OUTW-1:0]  log_q[$];
  logic [RATIO-1:0] mlog_q[$];
  int               clog_q[$];
  logic [OUTW-1:0]  fifo[$];
  bit               fifo_mode;
  int               cyc;

  task automatic model_reset();
    m_beats.delete();
    m_pend = 1'b0;
    m_data = '0;
    m_mask = '0;
  endtask

  task automatic clear_log();
    log_q.delete();
    mlog_q.delete();
    clog_q.delete();
  endtask

  task automatic step(input bit v, input logic [DATAW-1:0] d, input bit l, input bit f);
    bit acc, pushing, done;
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    in_last  = l;
    full     = fifo_mode ? (fifo.size() >= 4) : f;
    #1;
    chk("in_ready", in_ready, !(m_pend && full));
    chk("push",     push,     m_pend && !full);
    chk("data_out", data_out, m_data);
    chk("mask_out", mask_out, m_mask);
    chk("idle",     idle,     (m_beats.size() == 0) && !m_pend);
    if (push) begin
      log_q.push_back(data_out);
      mlog_q.push_back(mask_out);
      clog_q.push_back(cyc);
      if (fifo_mode) fifo.push_back(data_out);
    end
    cyc++;
    pushing = m_pend && !full;
    acc     = v && !(m_pend && full);
    done    = 1'b0;
    if (acc) begin
      m_beats.push_back(int'(d));
      if (m_beats.size() == RATIO || l) done = 1'b1;
    end
    if (done) begin
      m_data = '0;
      for (int k = 0; k < m_beats.size(); k++)
        m_data = m_data | (OUTW'(m_beats[k]) << (k * DATAW));
      m_mask = RATIO'((1 << m_beats.size()) - 1);
      m_beats.delete();
      m_pend = 1'b1;
    end else if (pushing) begin
      m_pend = 1'b0;
    end
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  logic [OUTW-1:0] exp_w[5];
  logic [DATAW-1:0] beat6[20];

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    full      = 1'b0;
    fifo_mode = 1'b0;
    cyc       = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_idle",     idle,     1'b1);
    chk("rst_push",     push,     1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_data",     data_out, 16'h0000);
    chk("rst_mask",     mask_out, 4'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: full word a,b,c,d
    clear_log();
    step(1, 4'ha, 0, 0); step(1, 4'hb, 0, 0); step(1, 4'hc, 0, 0); step(1, 4'hd, 0, 0);
    idle_steps(2);
    chk("t1_count", log_q.size(), 1);
    if (log_q.size() == 1) begin
      chk("t1_data", log_q[0], 16'hdcba);
      chk("t1_mask", mlog_q[0], 4'hf);
    end

    // 2: partial flushes
    clear_log();
    step(1, 4'he, 0, 0); step(1, 4'hf, 1, 0);
    idle_steps(1);
    step(1, 4'h7, 1, 0);
    idle_steps(2);
    chk("t2_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("t2_data0", log_q[0], 16'h00fe);
      chk("t2_mask0", mlog_q[0], 4'b0011);
      chk("t2_data1", log_q[1], 16'h0007);
      chk("t2_mask1", mlog_q[1], 4'b0001);
    end

    // 3: back-pressure while a word is pending
    clear_log();
    step(1, 4'h1, 0, 0); step(1, 4'h2, 0, 0); step(1, 4'h3, 0, 0); step(1, 4'h4, 0, 0);
    for (int i = 0; i < 5; i++) step(1'b1, 4'h5, 1'b0, 1'b1);
    chk("t3_no_push", log_q.size(), 0);
    idle_steps(2);
    chk("t3_count", log_q.size(), 1);
    if (log_q.size() == 1) chk("t3_data", log_q[0], 16'h4321);

    // 4: sustained throughput
    clear_log();
    for (int i = 1; i <= 8; i++) step(1'b1, DATAW'(i), 1'b0, 1'b0);
    idle_steps(2);
    chk("t4_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("t4_data0", log_q[0], 16'h4321);
      chk("t4_data1", log_q[1], 16'h8765);
      chk("t4_gap",   clog_q[1] - clog_q[0], 4);
    end

    // 5: asynchronous reset mid-word
    clear_log();
    step(1, 4'h1, 0, 0); step(1, 4'h2, 0, 0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_data", data_out, 16'h0000);
    chk("t5_mask", mask_out, 4'h0);
    chk("t5_idle", idle, 1'b1);
    model_reset();
    #1 reset_n = 1'b1;
    step(1, 4'h9, 0, 0); step(1, 4'ha, 0, 0); step(1, 4'hb, 0, 0); step(1, 4'hc, 0, 0);
    idle_steps(2);
    chk("t5_count", log_q.size(), 1);
    if (log_q.size() == 1) begin
      chk("t5_word", log_q[0], 16'hcba9);
      chk("t5_wmask", mlog_q[0], 4'hf);
    end

    // 6: into a depth-4 FIFO with no pops
    clear_log();
    fifo.delete();
    fifo_mode = 1'b1;
    for (int i = 0; i < 20; i++) beat6[i] = DATAW'($urandom);
    for (int w = 0; w < 5; w++) begin
      exp_w[w] = '0;
      for (int k = 0; k < RATIO; k++) exp_w[w] = exp_w[w] | (OUTW'(beat6[w*RATIO+k]) << (k*DATAW));
    end
    begin
      int bi = 0;
      for (int c = 0; c < 40; c++) begin
        if (bi < 20) begin
          step(1'b1, beat6[bi], 1'b0, 1'b0);
          if (in_ready) bi++;
        end else begin
          step(1'b0, '0, 1'b0, 1'b0);
        end
      end
      chk("t6_accepted", bi, 20);
    end
    chk("t6_pushes",   fifo.size(), 4);
    chk("t6_full",     full, 1'b1);
    chk("t6_push_off", push, 1'b0);
    chk("t6_ready",    in_ready, 1'b0);
    for (int w = 0; w < 4; w++) begin
      if (fifo.size() > 0) chk("t6_pop", fifo.pop_front(), exp_w[w]);
      else chk("t6_pop_empty", 0, 1);
    end
    idle_steps(2);
    chk("t6_last_push", fifo.size(), 1);
    if (fifo.size() == 1) chk("t6_last_word", fifo.pop_front(), exp_w[4]);
    fifo_mode = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 2000; i++)
      step(($urandom_range(0, 3) != 0), DATAW'($urandom), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 2) == 0));
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, 1'b0);
    chk("final_idle", idle, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
